// File: rtl/fwperiph_dma_dbg_trace.sv
// Debug trace capture for a DMA engine: timestamps register writes and busy/done
// edges into a first-word-fall-through FIFO with sticky overflow accounting.
module fwperiph_dma_dbg_trace #(
    parameter int ch_count = 1,
    parameter int depth    = 16,
    parameter int ts_width = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               adr,
    input  logic [31:0]               dat_w,
    input  logic                      we,
    input  logic [4:0]                ch_sel,
    input  logic                      dma_busy,
    input  logic                      dma_done_all,
    input  logic [ch_count-1:0]       ch_mask,
    input  logic                      trc_en,
    input  logic                      trc_clr,
    input  logic                      trc_rd,
    output logic                      trc_valid,
    output logic [ts_width+56:0]      trc_dat,
    output logic [$clog2(depth):0]    trc_count,
    output logic                      trc_ovf,
    output logic [15:0]               trc_drops
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam int rw = ts_width + 57;

    logic                busy_q;
    logic                done_q;
    logic [ts_width-1:0] ts_q;
    logic [rw-1:0]       mem [depth];
    logic [aw-1:0]       wr_ptr;
    logic [aw-1:0]       rd_ptr;
    logic [cw-1:0]       count_q;
    logic                ovf_q;
    logic [15:0]         drops_q;

    logic                w_hit;
    logic [3:0]          flags;
    logic                push;
    logic                pop;
    logic                full;
    logic                accept;
    logic [rw-1:0]       record;
    logic                unused_adr;

    assign unused_adr = ^adr[31:16];

    // Loop compare keeps ch_mask indexing in range for any ch_sel value.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < ch_count; i++) begin
            if (ch_sel == 5'(i)) w_hit = ch_mask[i];
        end
    end

    assign flags  = {we & w_hit, dma_busy & ~busy_q, ~dma_busy & busy_q, dma_done_all & ~done_q};
    assign push   = trc_en & (|flags);
    assign pop    = trc_rd & (count_q != '0);
    assign full   = (count_q == cw'(depth));
    assign accept = push & (~full | pop);

    assign record = flags[3] ? {ts_q, flags, ch_sel, adr[15:0], dat_w}
                             : {ts_q, flags, 5'd0, 16'd0, 32'd0};

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= dma_busy;
            done_q <= dma_done_all;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !reset && !trc_clr) mem[wr_ptr] <= record;
    end

    always_ff @(posedge clock) begin
        if (reset || trc_clr) begin
            ts_q    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drops_q <= 16'd0;
        end else begin
            if (trc_en) ts_q <= ts_q + 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && !accept) begin
                ovf_q <= 1'b1;
                if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
            end
        end
    end

    assign trc_valid = (count_q != '0);
    assign trc_dat   = mem[rd_ptr];
    assign trc_count = count_q;
    assign trc_ovf   = ovf_q;
    assign trc_drops = drops_q;

endmodule

// File: tb/tb_fwperiph_dma_dbg_trace.sv
// Randomized scoreboard bench for the DMA debug trace block (4 channels, depth 4, 4-bit timestamp).
module tb_fwperiph_dma_dbg_trace;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        we;
    logic [4:0]  ch_sel;
    logic        dma_busy;
    logic        dma_done_all;
    logic [3:0]  ch_mask;
    logic        trc_en;
    logic        trc_clr;
    logic        trc_rd;
    logic        trc_valid;
    logic [60:0] trc_dat;
    logic [2:0]  trc_count;
    logic        trc_ovf;
    logic [15:0] trc_drops;

    always #5 clock = ~clock;

    fwperiph_dma_dbg_trace #(.ch_count(4), .depth(4), .ts_width(4)) dut (
        .clock(clock), .reset(reset), .adr(adr), .dat_w(dat_w), .we(we),
        .ch_sel(ch_sel), .dma_busy(dma_busy), .dma_done_all(dma_done_all),
        .ch_mask(ch_mask), .trc_en(trc_en), .trc_clr(trc_clr), .trc_rd(trc_rd),
        .trc_valid(trc_valid), .trc_dat(trc_dat), .trc_count(trc_count),
        .trc_ovf(trc_ovf), .trc_drops(trc_drops)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of expected records plus plain counters.
    logic [60:0] exp_q[$];
    int          mcount;
    logic        movf;
    int          mdrops;
    logic [3:0]  mts;
    logic        pb, pd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected record.
    always @(posedge clock) begin
        if (!reset && !trc_clr && trc_rd && trc_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected actual=%h required=none", trc_dat);
            end else begin
                logic [60:0] e;
                e = exp_q.pop_front();
                if (trc_dat !== e) begin
                    n_fail++;
                    $display("FAIL pop_record actual=%h required=%h", trc_dat, e);
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        mcount = 0; movf = 1'b0; mdrops = 0; mts = 4'd0; pb = 1'b0; pd = 1'b0;
    endtask

    task automatic idle_inputs();
        we = 1'b0; trc_rd = 1'b0; trc_clr = 1'b0; ch_sel = 5'd0; adr = 32'd0; dat_w = 32'd0;
    endtask

    // Called at a negedge with inputs set; predicts, crosses one rising edge, checks.
    task automatic cycle();
        logic        w;
        logic [3:0]  fl;
        logic [60:0] rec;
        bit          do_pop;
        w = 1'b0;
        if (we && ch_sel < 5'd4) w = ch_mask[ch_sel[1:0]];
        fl  = {w, dma_busy && !pb, !dma_busy && pb, dma_done_all && !pd};
        rec = {mts, fl, w ? ch_sel : 5'd0, w ? adr[15:0] : 16'd0, w ? dat_w : 32'd0};
        pb = dma_busy;
        pd = dma_done_all;
        if (trc_clr) begin
            exp_q.delete();
            mcount = 0; movf = 1'b0; mdrops = 0; mts = 4'd0;
        end else begin
            do_pop = trc_rd && (mcount > 0);
            if (trc_en && fl != 4'd0) begin
                if (mcount < 4 || do_pop) begin
                    exp_q.push_back(rec);
                    mcount++;
                end else begin
                    movf = 1'b1;
                    if (mdrops < 65535) mdrops++;
                end
            end
            if (do_pop) mcount--;
            if (trc_en) mts = mts + 4'd1;
        end
        @(posedge clock);
        #1;
        chk("count", 64'(trc_count), 64'(mcount));
        chk("valid", 64'(trc_valid), 64'(mcount > 0));
        chk("ovf",   64'(trc_ovf),   64'(movf));
        chk("drops", 64'(trc_drops), 64'(mdrops));
        @(negedge clock);
    endtask

    task automatic do_reset(input logic busy_lvl);
        @(negedge clock);
        reset = 1'b1;
        dma_busy = busy_lvl;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("rst_count", 64'(trc_count), 64'd0);
        chk("rst_valid", 64'(trc_valid), 64'd0);
        chk("rst_ovf",   64'(trc_ovf),   64'd0);
        chk("rst_drops", 64'(trc_drops), 64'd0);
    endtask

    task automatic write_ev(input logic [4:0] ch, input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; ch_sel = ch; adr = a; dat_w = d;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        dma_busy = 1'b0; dma_done_all = 1'b0; ch_mask = 4'b0010; trc_en = 1'b0;
        model_reset();
        do_reset(1'b0);

        // Masked write capture with timestamp 3
        trc_en = 1'b1;
        repeat (3) cycle();
        write_ev(5'd1, 32'h0000_0010, 32'h0000_00A5);
        cycle();
        chk("mask_write_rec", 64'(trc_dat), 64'({4'd3, 4'b1000, 5'd1, 16'h0010, 32'h0000_00A5}));
        write_ev(5'd2, 32'h0000_0010, 32'h0000_00A5);
        cycle();
        chk("masked_off_ch2", 64'(trc_count), 64'd1);
        idle_inputs(); trc_rd = 1'b1;
        cycle();

        // Coalesced flags
        idle_inputs();
        dma_busy = 1'b1; write_ev(5'd1, 32'h1234_5678, 32'hDEAD_BEEF);
        cycle();
        chk("coalesce_w_br", 64'(trc_dat[56:53]), 64'(4'b1100));
        idle_inputs();
        dma_busy = 1'b0; dma_done_all = 1'b1;
        cycle();
        trc_rd = 1'b1;
        cycle(); cycle();
        trc_rd = 1'b0; dma_done_all = 1'b0;
        cycle();

        // Overflow: six events into depth 4
        trc_clr = 1'b1; cycle(); trc_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_ev(5'd1, 32'(i), 32'h100 + 32'(i));
            cycle();
        end
        chk("ovf_count", 64'(trc_count), 64'd4);
        chk("ovf_flag",  64'(trc_ovf),   64'd1);
        chk("ovf_drops", 64'(trc_drops), 64'd2);
        idle_inputs(); trc_rd = 1'b1;
        repeat (4) cycle();
        chk("drained", 64'(trc_valid), 64'd0);

        // Full FIFO with simultaneous push and pop
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            write_ev(5'd1, 32'h20 + 32'(i), 32'h200 + 32'(i));
            cycle();
        end
        write_ev(5'd1, 32'h0000_0077, 32'h0000_0777); trc_rd = 1'b1;
        cycle();
        chk("full_pushpop_count", 64'(trc_count), 64'd4);
        chk("full_pushpop_drops", 64'(trc_drops), 64'd2);
        idle_inputs(); trc_rd = 1'b1;
        repeat (4) cycle();

        // Empty FIFO with simultaneous push and pop
        write_ev(5'd1, 32'h33, 32'h333); trc_rd = 1'b1;
        cycle();
        chk("empty_pushpop", 64'(trc_count), 64'd1);
        idle_inputs(); trc_rd = 1'b1; cycle();

        // Timestamp wrap, then clear overriding a pending event
        idle_inputs();
        trc_clr = 1'b1; cycle(); trc_clr = 1'b0;
        repeat (17) cycle();
        write_ev(5'd1, 32'h44, 32'h444);
        cycle();
        chk("ts_wrap", 64'(trc_dat[60:57]), 64'd1);
        write_ev(5'd1, 32'h55, 32'h555); trc_clr = 1'b1;
        cycle();
        chk("clr_count", 64'(trc_count), 64'd0);
        idle_inputs();
        write_ev(5'd1, 32'h66, 32'h666);
        cycle();
        chk("clr_ts_zero", 64'(trc_dat[60:57]), 64'd0);
        idle_inputs(); trc_rd = 1'b1; cycle();

        // Busy already high across reset release gives a rise
        idle_inputs();
        do_reset(1'b1);
        cycle();
        chk("busy_after_reset", 64'(trc_dat[56:53]), 64'(4'b0100));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            we           = ($urandom_range(0, 1) == 1);
            ch_sel       = 5'($urandom_range(0, 7));
            adr          = $urandom;
            dat_w        = $urandom;
            if ($urandom_range(0, 3) == 0) dma_busy = ~dma_busy;
            if ($urandom_range(0, 4) == 0) dma_done_all = ~dma_done_all;
            if ($urandom_range(0, 19) == 0) ch_mask = 4'($urandom);
            trc_en       = ($urandom_range(0, 9) != 0);
            trc_clr      = ($urandom_range(0, 39) == 0);
            trc_rd       = ($urandom_range(0, 9) < 4);
            cycle();
        end
        idle_inputs(); trc_rd = 1'b1;
        repeat (6) cycle();
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
